// File: rtl/la_checkpoint_capture.sv
// la_checkpoint_capture: records each change of the la_output checkpoint field into a drainable FIFO.
// Optional LA_CKPT_TIMESTAMP_EN adds a free-running cycle timestamp to every entry.
module la_checkpoint_capture #(
    parameter int DEPTH    = 8,
    parameter int CKPT_LSB = 32,
    parameter int CKPT_W   = 6,
    parameter int DATA_LSB = 0
) (
    input  logic                     core_clk,
    input  logic                     core_rst,
    input  logic [127:0]             la_output,
    input  logic                     enable,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CKPT_W-1:0]        out_ckpt,
    output logic [31:0]              out_data,
    output logic [31:0]              out_time,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    input  logic                     clr_overflow
);
    localparam int AW = $clog2(DEPTH);

    logic [127:0]      la_q;
    logic              la_unused;
    logic [CKPT_W-1:0] ckpt_prev;
    logic [CKPT_W-1:0] ckpt_cur;
    logic [31:0]       data_cur;
    logic [AW:0]       wptr;
    logic [AW:0]       rptr;
    logic [CKPT_W-1:0] ckpt_mem [DEPTH];
    logic [31:0]       data_mem [DEPTH];
    logic              push;
    logic              pop;
    logic              full;
    logic              empty;
    logic              wr;

    assign la_unused = ^la_q;
    assign ckpt_cur  = la_q[CKPT_LSB +: CKPT_W];
    assign data_cur  = la_q[DATA_LSB +: 32];
    assign push      = enable && (ckpt_cur != ckpt_prev);
    assign empty     = wptr == rptr;
    assign full      = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign out_valid = !empty;
    assign pop       = out_valid && out_ready;
    // A full FIFO still accepts a push when the head leaves on the same edge
    assign wr        = push && (!full || pop);
    assign level     = wptr - rptr;
    assign out_ckpt  = out_valid ? ckpt_mem[rptr[AW-1:0]] : '0;
    assign out_data  = out_valid ? data_mem[rptr[AW-1:0]] : '0;

    always_ff @(posedge core_clk or posedge core_rst) begin
        if (core_rst) begin
            la_q      <= '0;
            ckpt_prev <= '0;
            wptr      <= '0;
            rptr      <= '0;
            overflow  <= 1'b0;
        end else begin
            la_q      <= la_output;
            ckpt_prev <= ckpt_cur;
            if (wr) wptr <= wptr + 1'b1;
            if (pop) rptr <= rptr + 1'b1;
            overflow  <= (push && full && !pop) || (overflow && !clr_overflow);
        end
    end

    always_ff @(posedge core_clk) begin
        if (wr) begin
            ckpt_mem[wptr[AW-1:0]] <= ckpt_cur;
            data_mem[wptr[AW-1:0]] <= data_cur;
        end
    end

`ifdef LA_CKPT_TIMESTAMP_EN
    logic [31:0] ts;
    logic [31:0] time_mem [DEPTH];

    always_ff @(posedge core_clk or posedge core_rst) begin
        if (core_rst) ts <= '0;
        else ts <= ts + 1'b1;
    end

    always_ff @(posedge core_clk) begin
        if (wr) time_mem[wptr[AW-1:0]] <= ts;
    end

    assign out_time = out_valid ? time_mem[rptr[AW-1:0]] : '0;
`else
    assign out_time = '0;
`endif
endmodule

// File: tb/tb_la_checkpoint_capture.sv
// tb_la_checkpoint_capture: directed self-checking bench for la_checkpoint_capture.
module tb_la_checkpoint_capture;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [127:0] la_output = '0;
    logic         enable = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [5:0]   out_ckpt;
    logic [31:0]  out_data;
    logic [31:0]  out_time;
    logic [3:0]   level;
    logic         overflow;
    logic         clr_overflow = 1'b0;
    logic [31:0]  cyc;
    int           total = 0;
    int           bad = 0;

    la_checkpoint_capture dut (
        .core_clk(clk), .core_rst(rst), .la_output(la_output), .enable(enable),
        .out_valid(out_valid), .out_ready(out_ready), .out_ckpt(out_ckpt),
        .out_data(out_data), .out_time(out_time), .level(level),
        .overflow(overflow), .clr_overflow(clr_overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= '0;
        else cyc <= cyc + 1;
    end

    function automatic logic [31:0] exp_time(input logic [31:0] t);
`ifdef LA_CKPT_TIMESTAMP_EN
        return t;
`else
        return 32'd0;
`endif
    endfunction

    task automatic set_la(input logic [5:0] c, input logic [31:0] d);
        la_output = '0;
        la_output[37:32] = c;
        la_output[31:0] = d;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0h exp=0", out_valid); end
        total++; if (out_ckpt !== 6'h0) begin bad++; $display("FAIL reset_ckpt got=%0h exp=0", out_ckpt); end
        total++; if (out_data !== 32'h0) begin bad++; $display("FAIL reset_data got=%0h exp=0", out_data); end
        total++; if (out_time !== 32'h0) begin bad++; $display("FAIL reset_time got=%0h exp=0", out_time); end
        total++; if (level !== 4'd0) begin bad++; $display("FAIL reset_level got=%0d exp=0", level); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%0h exp=0", overflow); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single;
        logic [31:0] t;
        enable = 1'b1;
        set_la(6'h0A, 32'h12345678);
        @(negedge clk);
        t = cyc;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_latency got=%0h exp=0", out_valid); end
        @(negedge clk);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%0h exp=1", out_valid); end
        total++; if (out_ckpt !== 6'h0A) begin bad++; $display("FAIL single_ckpt got=%0h exp=0a", out_ckpt); end
        total++; if (out_data !== 32'h12345678) begin bad++; $display("FAIL single_data got=%0h exp=12345678", out_data); end
        total++; if (out_time !== exp_time(t)) begin bad++; $display("FAIL single_time got=%0h exp=%0h", out_time, exp_time(t)); end
        repeat (2) @(negedge clk);
        total++; if (level !== 4'd1) begin bad++; $display("FAIL single_hold_level got=%0d exp=1", level); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        total++; if (level !== 4'd0) begin bad++; $display("FAIL single_pop_level got=%0d exp=0", level); end
        total++; if (out_ckpt !== 6'h0) begin bad++; $display("FAIL single_empty_ckpt got=%0h exp=0", out_ckpt); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] t0;
        for (int i = 1; i <= 5; i++) begin
            set_la(6'(i), 32'hD000_0000 + 32'(i));
            @(negedge clk);
            if (i == 1) t0 = cyc;
        end
        @(negedge clk);
        total++; if (level !== 4'd5) begin bad++; $display("FAIL b2b_level got=%0d exp=5", level); end
        out_ready = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            total++; if (out_ckpt !== 6'(i)) begin bad++; $display("FAIL b2b_ckpt%0d got=%0h exp=%0h", i, out_ckpt, i); end
            total++; if (out_data !== 32'hD000_0000 + 32'(i)) begin bad++; $display("FAIL b2b_data%0d got=%0h", i, out_data); end
            total++; if (out_time !== exp_time(t0 + 32'(i - 1))) begin bad++; $display("FAIL b2b_time%0d got=%0h exp=%0h", i, out_time, exp_time(t0 + 32'(i - 1))); end
            @(negedge clk);
        end
        out_ready = 1'b0;
        total++; if (level !== 4'd0) begin bad++; $display("FAIL b2b_drained got=%0d exp=0", level); end
    endtask

    task automatic test_overflow;
        for (int i = 0; i < 10; i++) begin
            set_la(6'h10 + 6'(i), 32'hA0 + 32'(i));
            @(negedge clk);
        end
        @(negedge clk);
        total++; if (level !== 4'd8) begin bad++; $display("FAIL ovf_level got=%0d exp=8", level); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%0h exp=1", overflow); end
        total++; if (out_ckpt !== 6'h10) begin bad++; $display("FAIL ovf_head got=%0h exp=10", out_ckpt); end
        set_la(6'h1A, 32'hAA);
        @(negedge clk);
        clr_overflow = 1'b1;
        @(negedge clk);
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_clr_vs_drop got=%0h exp=1", overflow); end
        @(negedge clk);
        clr_overflow = 1'b0;
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clr got=%0h exp=0", overflow); end
        total++; if (level !== 4'd8) begin bad++; $display("FAIL ovf_level2 got=%0d exp=8", level); end
    endtask

    task automatic test_full_push_pop;
        logic [5:0] exp_q [8];
        exp_q = '{6'h11, 6'h12, 6'h13, 6'h14, 6'h15, 6'h16, 6'h17, 6'h1B};
        set_la(6'h1B, 32'hBB);
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        total++; if (level !== 4'd8) begin bad++; $display("FAIL full_pp_level got=%0d exp=8", level); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL full_pp_overflow got=%0h exp=0", overflow); end
        total++; if (out_ckpt !== 6'h11) begin bad++; $display("FAIL full_pp_head got=%0h exp=11", out_ckpt); end
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            total++; if (out_ckpt !== exp_q[i]) begin bad++; $display("FAIL full_pp_order%0d got=%0h exp=%0h", i, out_ckpt, exp_q[i]); end
            @(negedge clk);
        end
        out_ready = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL full_pp_drained got=%0h exp=0", out_valid); end
    endtask

    task automatic test_enable;
        enable = 1'b0;
        set_la(6'h00, 32'h0);
        repeat (3) @(negedge clk);
        set_la(6'h03, 32'h33);
        repeat (3) @(negedge clk);
        enable = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (level !== 4'd0) begin bad++; $display("FAIL en_gated got=%0d exp=0", level); end
        set_la(6'h01, 32'h11);
        repeat (4) @(negedge clk);
        total++; if (level !== 4'd1) begin bad++; $display("FAIL en_one_entry got=%0d exp=1", level); end
        total++; if (out_ckpt !== 6'h01) begin bad++; $display("FAIL en_ckpt got=%0h exp=01", out_ckpt); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid;
        for (int i = 1; i <= 4; i++) begin
            set_la(6'h20 + 6'(i), 32'hC0 + 32'(i));
            @(negedge clk);
        end
        @(negedge clk);
        total++; if (level !== 4'd4) begin bad++; $display("FAIL rmid_pre_level got=%0d exp=4", level); end
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        total++; if (level !== 4'd0) begin bad++; $display("FAIL rmid_level got=%0d exp=0", level); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rmid_valid got=%0h exp=0", out_valid); end
        total++; if ({out_ckpt, out_data, out_time} !== 70'h0) begin bad++; $display("FAIL rmid_outs got=%0h exp=0", {out_ckpt, out_data, out_time}); end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (out_ckpt !== 6'h24) begin bad++; $display("FAIL rmid_recapture got=%0h exp=24", out_ckpt); end
        total++; if (out_time !== exp_time(32'd1)) begin bad++; $display("FAIL rmid_ts_restart got=%0h exp=%0h", out_time, exp_time(32'd1)); end
        total++; if (level !== 4'd1) begin bad++; $display("FAIL rmid_level_after got=%0d exp=1", level); end
    endtask

    initial begin
        test_reset;
        test_single;
        test_back_to_back;
        test_overflow;
        test_full_push_pop;
        test_enable;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
